// File: rtl/alu_seq.sv
// alu_seq: registered ALU with Start/Busy/Done handshake.
// Single-cycle ops complete one clock after an accepted Start.
// Optional feature macro ALU_MUL_EN: when defined, opcode 9 is an iterative
// shift-add unsigned multiply (WIDTH+1 clocks, 2*WIDTH-bit product); when
// undefined, opcode 9 behaves like the reserved opcodes.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             nRst,
    input  logic             Start,
    input  logic [3:0]       ALUCode,
    input  logic [WIDTH-1:0] Accu,
    input  logic [WIDTH-1:0] MemIn,
    input  logic             Ci,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Out,
    output logic [WIDTH-1:0] OutHi,
    output logic             Co,
    output logic             Zf,
    output logic             Nf,
    output logic             Vf
);

    localparam int unsigned W   = WIDTH;
    localparam int unsigned WP1 = WIDTH + 1;
`ifdef ALU_MUL_EN
    localparam int unsigned CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_DONE
`ifdef ALU_MUL_EN
        , S_MUL
`endif
    } state_t;

    state_t state;

    logic [W-1:0] res_c;
    logic [W:0]   sum_c;
    logic         co_c;
    logic         vf_c;

`ifdef ALU_MUL_EN
    logic [W-1:0]  mcand;
    logic [W-1:0]  p_hi;
    logic [W-1:0]  p_lo;
    logic [CW-1:0] cnt;
    logic [W:0]    step_sum_c;
    logic [W-1:0]  step_hi_c;
    logic [W-1:0]  step_lo_c;

    // One shift-add step: add multiplicand on multiplier LSB, shift product right.
    always_comb begin
        step_sum_c = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : WP1'(0));
        step_hi_c  = step_sum_c[W:1];
        step_lo_c  = {step_sum_c[0], p_lo[W-1:1]};
    end
`endif

    // Single-cycle result and flags computed from the live operand inputs.
    always_comb begin
        res_c = '0;
        sum_c = '0;
        co_c  = 1'b0;
        vf_c  = 1'b0;
        case (ALUCode)
            4'd0: begin
                sum_c = {1'b0, Accu} + {1'b0, MemIn} + WP1'(Ci);
                res_c = sum_c[W-1:0];
                co_c  = sum_c[W];
                vf_c  = (Accu[W-1] == MemIn[W-1]) && (res_c[W-1] != Accu[W-1]);
            end
            4'd1: begin
                sum_c = {1'b0, Accu} - {1'b0, MemIn} - WP1'(Ci);
                res_c = sum_c[W-1:0];
                co_c  = sum_c[W];
                vf_c  = (Accu[W-1] != MemIn[W-1]) && (res_c[W-1] != Accu[W-1]);
            end
            4'd2: res_c = Accu & MemIn;
            4'd3: res_c = Accu | MemIn;
            4'd4: res_c = Accu ^ MemIn;
            4'd5: res_c = ~Accu;
            4'd6: res_c = MemIn;
            4'd7: begin
                res_c = {Accu[W-2:0], Ci};
                co_c  = Accu[W-1];
            end
            4'd8: begin
                res_c = {Ci, Accu[W-1:1]};
                co_c  = Accu[0];
            end
            default: res_c = '0;
        endcase
    end

    // Handshake FSM with registered result, flags, Busy and Done.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            state <= S_IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            Out   <= '0;
            OutHi <= '0;
            Co    <= 1'b0;
            Zf    <= 1'b0;
            Nf    <= 1'b0;
            Vf    <= 1'b0;
`ifdef ALU_MUL_EN
            mcand <= '0;
            p_hi  <= '0;
            p_lo  <= '0;
            cnt   <= '0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (Start) begin
`ifdef ALU_MUL_EN
                        if (ALUCode == 4'd9) begin
                            mcand <= Accu;
                            p_hi  <= '0;
                            p_lo  <= MemIn;
                            cnt   <= '0;
                            Busy  <= 1'b1;
                            state <= S_MUL;
                        end else
`endif
                        begin
                            Out   <= res_c;
                            OutHi <= '0;
                            Co    <= co_c;
                            Zf    <= (res_c == '0);
                            Nf    <= res_c[W-1];
                            Vf    <= vf_c;
                            Done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    if (cnt == CW'(W - 1)) begin
                        Out   <= step_lo_c;
                        OutHi <= step_hi_c;
                        Co    <= 1'b0;
                        Vf    <= 1'b0;
                        Zf    <= ({step_hi_c, step_lo_c} == '0);
                        Nf    <= step_hi_c[W-1];
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        p_hi <= step_hi_c;
                        p_lo <= step_lo_c;
                        cnt  <= cnt + CW'(1);
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases plus random ops at WIDTH=8,
// and a WIDTH=16 instance, checked against an arithmetic reference model.
module tb_alu_seq;

    logic        Clk = 1'b0;
    logic        nRst;

    logic        st8, ci8, busy8, done8, co8, zf8, nf8, vf8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, out8, hi8;

    logic        st16, ci16, busy16, done16, co16, zf16, nf16, vf16;
    logic [3:0]  op16;
    logic [15:0] a16, b16, out16, hi16;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(8)) dut8 (
        .Clk(Clk), .nRst(nRst), .Start(st8), .ALUCode(op8), .Accu(a8), .MemIn(b8),
        .Ci(ci8), .Busy(busy8), .Done(done8), .Out(out8), .OutHi(hi8), .Co(co8),
        .Zf(zf8), .Nf(nf8), .Vf(vf8)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .Clk(Clk), .nRst(nRst), .Start(st16), .ALUCode(op16), .Accu(a16), .MemIn(b16),
        .Ci(ci16), .Busy(busy16), .Done(done16), .Out(out16), .OutHi(hi16), .Co(co16),
        .Zf(zf16), .Nf(nf16), .Vf(vf16)
    );

    always #5 Clk = ~Clk;

    // Reference model: plain integer arithmetic on the opcode rules.
    function automatic void model(input int w, input int op, input longint a, input longint b,
                                  input int ci, output longint out, output longint hi,
                                  output int co, output int zf, output int nf, output int vf,
                                  output int lat);
        longint m, half, s, sa, sb, ss;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        sa   = (a >= half) ? a - (longint'(1) << w) : a;
        sb   = (b >= half) ? b - (longint'(1) << w) : b;
        out = 0; hi = 0; co = 0; vf = 0; lat = 1;
        case (op)
            0: begin
                s = a + b + ci; out = s & m; co = int'(s > m);
                ss = sa + sb + ci; vf = int'(ss >= half || ss < -half);
            end
            1: begin
                s = a - b - ci; out = s & m; co = int'(s < 0);
                ss = sa - sb - ci; vf = int'(ss >= half || ss < -half);
            end
            2: out = a & b;
            3: out = a | b;
            4: out = a ^ b;
            5: out = (~a) & m;
            6: out = b;
            7: begin out = (a * 2 + ci) & m; co = int'(a >= half); end
            8: begin out = a / 2 + ci * half; co = int'(a % 2); end
            9: begin
`ifdef ALU_MUL_EN
                s = a * b; out = s & m; hi = s >> w; lat = w + 1;
`endif
            end
            default: out = 0;
        endcase
        zf = int'(out == 0 && hi == 0);
        nf = (op == 9 && lat > 1) ? int'((hi >> (w - 1)) & 1) : int'((out >> (w - 1)) & 1);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input longint exp);
        total++;
        assert (obs === 32'(exp)) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic ci);
        if (w == 8) begin
            st8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0]; ci8 = ci;
        end else begin
            st16 = st; op16 = op; a16 = a; b16 = b; ci16 = ci;
        end
    endtask

    task automatic sample(input int w, output logic [31:0] out, output logic [31:0] hi,
                          output logic busy, output logic done, output logic co,
                          output logic zf, output logic nf, output logic vf);
        if (w == 8) begin
            out = {24'd0, out8}; hi = {24'd0, hi8};
            busy = busy8; done = done8; co = co8; zf = zf8; nf = nf8; vf = vf8;
        end else begin
            out = {16'd0, out16}; hi = {16'd0, hi16};
            busy = busy16; done = done16; co = co16; zf = zf16; nf = nf16; vf = vf16;
        end
    endtask

    task automatic drive_idle(input int w);
        drive(w, 1'b0, 4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    endtask

    // Launch one op, check Busy/Done timing and the result, then the Done pulse end.
    task automatic run_op(input int w, input int op, input longint a, input longint b,
                          input int ci, input string tag, input bit inject);
        longint eo, eh;
        int ec, ez, en, ev, lat;
        logic [31:0] o, h;
        logic bs, dn, c, z, n, v;
        model(w, op, a, b, ci, eo, eh, ec, ez, en, ev, lat);
        drive(w, 1'b1, 4'(op), 16'(a), 16'(b), 1'(ci));
        tick();
        for (int cyc = 1; cyc < lat; cyc++) begin
            if (inject && cyc == 3)
                drive(w, 1'b1, 4'd0, 16'($urandom), 16'($urandom), 1'b1);
            else
                drive_idle(w);
            sample(w, o, h, bs, dn, c, z, n, v);
            chk({tag, "_busy"}, 32'(bs), 1);
            chk({tag, "_early_done"}, 32'(dn), 0);
            tick();
        end
        drive_idle(w);
        sample(w, o, h, bs, dn, c, z, n, v);
        chk({tag, "_done"}, 32'(dn), 1);
        chk({tag, "_busy_end"}, 32'(bs), 0);
        chk({tag, "_out"}, o, eo);
        chk({tag, "_outhi"}, h, eh);
        chk({tag, "_co"}, 32'(c), ec);
        chk({tag, "_zf"}, 32'(z), ez);
        chk({tag, "_nf"}, 32'(n), en);
        chk({tag, "_vf"}, 32'(v), ev);
        tick();
        sample(w, o, h, bs, dn, c, z, n, v);
        chk({tag, "_done_pulse"}, 32'(dn), 0);
    endtask

    // Main directed + random sequence.
    initial begin
        logic [31:0] o, h;
        logic bs, dn, c, z, n, v;

        nRst = 1'b0;
        drive(8, 1'b1, 4'd0, 16'h00F0, 16'h0020, 1'b1);
        drive(16, 1'b1, 4'd0, 16'h1234, 16'h4321, 1'b1);
        repeat (3) tick();
        sample(8, o, h, bs, dn, c, z, n, v);
        chk("rst_out", o, 0);
        chk("rst_outhi", h, 0);
        chk("rst_busy", 32'(bs), 0);
        chk("rst_done", 32'(dn), 0);
        chk("rst_flags", {28'd0, c, z, n, v}, 0);
        sample(16, o, h, bs, dn, c, z, n, v);
        chk("rst16_state", {o[15:0], 6'd0, bs, dn, c, z, n, v}, 0);

        drive(8, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
        drive(16, 1'b0, 4'd0, 16'h0, 16'h0, 1'b0);
        nRst = 1'b1;
        repeat (3) begin
            tick();
            sample(8, o, h, bs, dn, c, z, n, v);
            chk("post_rst_no_done", 32'(dn), 0);
        end

        run_op(8, 0, 'hF0, 'h20, 1, "add_carry", 1'b0);
        run_op(8, 0, 'h7F, 'h01, 0, "add_ovf", 1'b0);
        run_op(8, 1, 'h10, 'h20, 0, "sub_borrow", 1'b0);
        run_op(8, 1, 'h05, 'h05, 0, "sub_zero", 1'b0);
        run_op(8, 9, 'hFF, 'hFF, 0, "mul_ff", 1'b1);

        // Back-to-back SHL then SHR on consecutive cycles.
        drive(8, 1'b1, 4'd7, 16'h0081, 16'h0, 1'b1);
        tick();
        drive(8, 1'b1, 4'd8, 16'h0001, 16'h0, 1'b0);
        sample(8, o, h, bs, dn, c, z, n, v);
        chk("b2b_shl_done", 32'(dn), 1);
        chk("b2b_shl_out", o, 'h03);
        chk("b2b_shl_co", 32'(c), 1);
        tick();
        drive_idle(8);
        sample(8, o, h, bs, dn, c, z, n, v);
        chk("b2b_shr_done", 32'(dn), 1);
        chk("b2b_shr_out", o, 'h00);
        chk("b2b_shr_co", 32'(c), 1);
        chk("b2b_shr_zf", 32'(z), 1);
        tick();
        sample(8, o, h, bs, dn, c, z, n, v);
        chk("b2b_done_end", 32'(dn), 0);

        for (int i = 0; i < 40; i++)
            run_op(8, int'($urandom_range(0, 15)), longint'($urandom_range(0, 255)),
                   longint'($urandom_range(0, 255)), int'($urandom_range(0, 1)), "rnd8", 1'b0);

        // Reset in the middle of a multiply.
        run_op(8, 6, 'h00, 'h5A, 0, "ld_pre_rst", 1'b0);
        drive(8, 1'b1, 4'd9, 16'h00FF, 16'h00FF, 1'b0);
        tick();
        drive_idle(8);
        repeat (3) tick();
        nRst = 1'b0;
        #1;
        sample(8, o, h, bs, dn, c, z, n, v);
        chk("midrst_busy", 32'(bs), 0);
        chk("midrst_out", o, 0);
        chk("midrst_outhi", h, 0);
        chk("midrst_done", 32'(dn), 0);
        tick();
        nRst = 1'b1;
        repeat (11) begin
            tick();
            sample(8, o, h, bs, dn, c, z, n, v);
            chk("midrst_no_done", 32'(dn), 0);
        end

        run_op(16, 9, 'hFFFF, 'h0002, 0, "mul16", 1'b0);
        run_op(16, 0, 'h7FFF, 'h0001, 0, "add16_ovf", 1'b0);
        for (int i = 0; i < 12; i++)
            run_op(16, int'($urandom_range(0, 15)), longint'($urandom_range(0, 65535)),
                   longint'($urandom_range(0, 65535)), int'($urandom_range(0, 1)), "rnd16", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor of the datapath ALU: WIDTH-bit operands, registered result and flags (carry, zero, negative, overflow), and a Start/Busy/Done handshake. Single-cycle ops complete one clock after Start. An iterative shift-add multiply takes WIDTH+1 clocks and returns a 2*WIDTH-bit product. Sits between accumulator/memory operand muxes and the accumulator write-back in the control FSM.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
Clk  input  1  system clock, rising edge
nRst  input  1  asynchronous active-low reset
Start  input  1  launch operation; sampled only when Busy=0
ALUCode  input  4  opcode, captured on accepted Start
Accu  input  WIDTH  operand A (accumulator), captured on accepted Start
MemIn  input  WIDTH  operand B (register/memory), captured on accepted Start
Ci  input  1  carry/borrow in, captured on accepted Start
Busy  output  1  operation in progress; new Start ignored
Done  output  1  one-cycle pulse, Out/OutHi/flags valid from this cycle on
Out  output  WIDTH  result (low half for MUL)
OutHi  output  WIDTH  high half of product for MUL; 0 for all other ops
Co  output  1  carry out (ADD), borrow out (SUB), last bit shifted out (SHL/SHR), else 0
Zf  output  1  {OutHi,Out}==0
Nf  output  1  Out[WIDTH-1] (OutHi[WIDTH-1] for MUL)
Vf  output  1  signed overflow for ADD/SUB, else 0

Behaviour:
- Reset: async on nRst low; Busy, Done, Out, OutHi, Co, Zf, Nf, Vf all 0; FSM to IDLE. Reset mid-MUL aborts it; no Done.
- Opcodes: 0 ADD {Co,Out}=A+B+Ci; 1 SUB {Co,Out}=A-B-Ci (Co=1 on borrow); 2 AND; 3 OR; 4 XOR; 5 NOT ~A; 6 LD Out=B; 7 SHL Out=A<<1, LSB=Ci, Co=A[WIDTH-1]; 8 SHR Out=A>>1, MSB=Ci, Co=A[0]; 9 MUL unsigned {OutHi,Out}=A*B; 10-15 reserved: Out=0, all flags 0 except Zf=1, Done pulses normally.
- Vf: ADD = A,B same sign and Out sign differs; SUB = A,B signs differ and Out sign differs from A.
- FSM: IDLE, MUL, DONE.
- IDLE, Start=1, non-MUL: result/flags registered at that edge, Done=1 next cycle, Busy stays 0 (back-to-back Start each cycle allowed, one Done per Start).
- IDLE, Start=1, MUL: operands latched, Busy=1, iteration counter=0 -> MUL.
- MUL: one shift-add step per clock, WIDTH steps; after last step write {OutHi,Out} and flags, -> DONE.
- DONE: Done=1, Busy=0 this cycle; a Start in DONE is accepted as if in IDLE. Total MUL latency Start-edge to Done = WIDTH+1 clocks.
- Start while Busy=1 ignored; operand inputs may change freely while Busy.
- Out/OutHi/flags hold last result until next completion; Done never high two cycles for one operation.
- Operands held in internal registers; outputs never combinationally depend on inputs.

Optional Feature:
ALU_MUL_EN: defined -> opcode 9 is the iterative multiplier as above. Undefined -> no multiplier logic or MUL state; opcode 9 is treated as reserved (single-cycle, Out=OutHi=0, Zf=1, Done next cycle, Busy never asserts).

Test Plan:
- Reset: hold nRst=0 with Start=1 -> all outputs 0; release, no Done until a Start is accepted.
- ADD WIDTH=8: A=0xF0, B=0x20, Ci=1 -> next cycle Out=0x11, Co=1, Vf=0, Zf=0, Done=1 for one cycle; A=0x7F, B=0x01, Ci=0 -> Out=0x80, Vf=1, Nf=1.
- SUB: A=0x10, B=0x20, Ci=0 -> Out=0xF0, Co=1, Nf=1; A=0x05, B=0x05, Ci=0 -> Out=0, Zf=1, Co=0.
- MUL (ALU_MUL_EN): A=0xFF, B=0xFF -> Busy 8 cycles, Done at cycle 9, OutHi=0xFE, Out=0x01; a Start with ADD issued mid-multiply is ignored.
- Back-to-back: SHL A=0x81, Ci=1 then SHR A=0x01, Ci=0 on consecutive cycles -> Out=0x03/Co=1, then Out=0x00/Co=1/Zf=1; two Done pulses.
- Reset mid-MUL at cycle 4 -> Busy=0, Out=0, no Done; WIDTH=16 rerun of MUL 0xFFFF*0x0002 -> OutHi=0x0001, Out=0xFFFE after 17 cycles.
